// File: rtl/sync_pkg.sv
// Shared types and limits for the pulse handshake transmitter and its ack synchronizer.
package sync_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } hs_state_t;

    // Fewer than two stages leaves no settling time for a metastable first flop.
    localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_chain.sv
// N-stage flop synchronizer bringing a single asynchronous level into the clk domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// Four-phase req/ack source: turns clk-domain event pulses into req levels, queuing events that arrive while busy.
module pulse_handshake_tx
    import sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pulse_in,
    input  logic              ack_async,
    input  logic              clr_ovf,
    output logic              req,
    output logic              busy,
    output logic              done,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync_stages
        $error("pulse_handshake_tx: SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
    end

    logic ack_s;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (ack_async),
        .sync_o  (ack_s)
    );

    hs_state_t         state_q, state_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;

    logic have_event;
    logic launch;
    logic pulse_used;
    logic pend_take;
    logic pulse_left;
    logic drop;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        launch     = 1'b0;
        have_event = pulse_in || (pending_q != '0);

        unique case (state_q)
            IDLE: begin
                // A stale ack (e.g. reset mid-handshake) blocks launching; events are queued instead.
                if (have_event && !ack_s) begin
                    state_d = REQ;
                    launch  = 1'b1;
                end
            end
            REQ: begin
                if (ack_s) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    done_d = 1'b1;
                    if (have_event) begin
                        state_d = REQ;
                        launch  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A launch prefers the live pulse; only without one does it drain the queue.
        pulse_used = launch && pulse_in;
        pend_take  = launch && !pulse_in;
        pulse_left = pulse_in && !pulse_used;
        drop       = pulse_left && (pending_q == PEND_MAX);

        pending_d = pending_q;
        if (pend_take) begin
            pending_d = pending_q - PEND_ONE;
        end else if (pulse_left && !drop) begin
            pending_d = pending_q + PEND_ONE;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        req_d  = (state_d == REQ);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign req      = req_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule
